// File: rtl/sar_cmp_responder_if.sv
// Bus between the SAR converter (master side) and the comparator responder
// (slave side). Carries the target load request, the SAR trial/done pair,
// the comparator answer and the check statistics.
interface sar_cmp_responder_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);

  logic [WIDTH-1:0]     target_in;
  logic                 target_load;
  logic [WIDTH-1:0]     trial_code;
  logic                 sar_done;
  logic                 comp_out;
  logic                 busy;
  logic [WIDTH-1:0]     result;
  logic                 result_valid;
  logic                 match;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] pass_cnt;
  logic [CNT_WIDTH-1:0] fail_cnt;

  // Driver side: the SAR plus whoever requests a conversion check.
  modport master (
    output target_in,
    output target_load,
    output trial_code,
    output sar_done,
    input  comp_out,
    input  busy,
    input  result,
    input  result_valid,
    input  match,
    input  timeout,
    input  pass_cnt,
    input  fail_cnt
  );

  // Responder side: answers trials and reports the outcome.
  modport slave (
    input  target_in,
    input  target_load,
    input  trial_code,
    input  sar_done,
    output comp_out,
    output busy,
    output result,
    output result_valid,
    output match,
    output timeout,
    output pass_cnt,
    output fail_cnt
  );

endinterface

// File: rtl/sar_cmp_responder.sv
// Digital stand-in for the analog front end of an 8-bit SAR converter.
// Holds a target code, answers each SAR trial with a registered comparator
// bit (1 = target >= trial), captures the final code on sar_done, compares
// it with the target and keeps saturating pass/fail statistics. A SAR that
// stays in CONVERT for TIMEOUT_CYCLES cycles is counted as a failure.
// TIMEOUT_CYCLES must be at least WIDTH+2 so a healthy SAR always finishes.
//
// Optional build macro SAR_LFSR_EN: when defined, targets come from an
// internal 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) that advances on
// every accepted load, and target_in is ignored.
module sar_cmp_responder #(
  parameter int WIDTH          = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                rst_n,
  sar_cmp_responder_if.slave bus
);

  // The cycle counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]        CYC_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    CHECK   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [TW-1:0]        cyc_q, cyc_d;
  logic                 comp_q, comp_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 match_q, match_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [CNT_WIDTH-1:0] fail_q, fail_d;

  // Value latched into the target register when a load is accepted.
  logic [WIDTH-1:0]     load_value;
  logic                 final_match;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

`ifdef SAR_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_next;
  logic       unused_target_in;

  // One Fibonacci step: feedback from bits 8,6,5,4 shifted in at the LSB.
  always_comb begin
    lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Narrower targets take the low LFSR bits, wider ones zero-fill the top.
  assign load_value       = WIDTH'(lfsr_q);
  assign unused_target_in = ^bus.target_in;
`else
  assign load_value = bus.target_in;
`endif

  assign final_match = (bus.trial_code == target_q);

  // Next-state and next-output computation for the IDLE/CONVERT/CHECK flow.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    result_d  = result_q;
    cyc_d     = cyc_q;
    comp_d    = comp_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    timeout_d = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
`ifdef SAR_LFSR_EN
    lfsr_d    = lfsr_q;
`endif

    unique case (state_q)
      IDLE: begin
        comp_d = 1'b0;
        busy_d = 1'b0;
        if (bus.target_load) begin
          target_d = load_value;
          cyc_d    = '0;
          busy_d   = 1'b1;
          state_d  = CONVERT;
`ifdef SAR_LFSR_EN
          lfsr_d   = lfsr_next;
`endif
        end
      end

      CONVERT: begin
        comp_d = (target_q >= bus.trial_code);
        cyc_d  = cyc_q + 1'b1;
        if (bus.sar_done) begin
          // Done wins over a timeout landing on the same cycle.
          result_d = bus.trial_code;
          match_d  = final_match;
          valid_d  = 1'b1;
          if (final_match) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
          end
          state_d = CHECK;
        end else if (cyc_q == CYC_LAST) begin
          timeout_d = 1'b1;
          fail_d    = sat_inc(fail_q);
          comp_d    = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      CHECK: begin
        comp_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        comp_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      result_q  <= '0;
      cyc_q     <= '0;
      comp_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
`ifdef SAR_LFSR_EN
      lfsr_q    <= 8'hA5;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      result_q  <= result_d;
      cyc_q     <= cyc_d;
      comp_q    <= comp_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
`ifdef SAR_LFSR_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign bus.comp_out     = comp_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.match        = match_q;
  assign bus.timeout      = timeout_q;
  assign bus.pass_cnt     = pass_q;
  assign bus.fail_cnt     = fail_q;

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Directed bench for sar_cmp_responder: reset values, comparator latency,
// a reference SAR binary search, wrong final code, timeout, counter
// saturation and (with SAR_LFSR_EN) the LFSR target sequence.
`timescale 1ns/1ps
module tb_sar_cmp_responder;

  localparam int WIDTH          = 8;
  localparam int CNT_WIDTH      = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] trial;
    logic       expComp;
  } cmpVec_t;

  typedef struct {
    logic [7:0] target;
    logic [7:0] expResult;
    logic       expMatch;
  } convVec_t;

  sar_cmp_responder_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus();

  sar_cmp_responder #(
    .WIDTH(WIDTH),
    .CNT_WIDTH(CNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic [7:0] tgt,
                               input logic [7:0] trial, input logic done);
    bus.target_load = load;
    bus.target_in   = tgt;
    bus.trial_code  = trial;
    bus.sar_done    = done;
    tick();
  endtask

  task automatic checkIdle(input string tag, input logic [7:0] expPass,
                           input logic [7:0] expFail);
    checkOutput({tag, " busy"},     32'(bus.busy), 32'd0);
    checkOutput({tag, " comp_out"}, 32'(bus.comp_out), 32'd0);
    checkOutput({tag, " valid"},    32'(bus.result_valid), 32'd0);
    checkOutput({tag, " timeout"},  32'(bus.timeout), 32'd0);
    checkOutput({tag, " pass_cnt"}, 32'(bus.pass_cnt), 32'(expPass));
    checkOutput({tag, " fail_cnt"}, 32'(bus.fail_cnt), 32'(expFail));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  // Reference SAR: one trial per cycle, keep the bit when comp_out says so.
  task automatic runSar(input logic [7:0] target, input logic [7:0] expResult,
                        input logic expMatch);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    applyStimulus(1'b1, target, 8'h00, 1'b0);
    for (int b = 7; b >= 0; b--) begin
      t = acc | 8'(1 << b);
      applyStimulus(1'b0, 8'h00, t, 1'b0);
      if (bus.comp_out) acc = t;
    end
    applyStimulus(1'b0, 8'h00, acc, 1'b1);
    checkOutput("sar valid", 32'(bus.result_valid), 32'd1);
    checkOutput("sar result", 32'(bus.result), 32'(expResult));
    checkOutput("sar match", 32'(bus.match), 32'(expMatch));
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("sar valid pulse end", 32'(bus.result_valid), 32'd0);
    checkOutput("sar result hold", 32'(bus.result), 32'(expResult));
    checkOutput("sar match hold", 32'(bus.match), 32'(expMatch));
  endtask

  // Main directed sequence.
  initial begin
    cmpVec_t  cmpVec[8];
    convVec_t convVec[4];
    int       seen;
    logic [7:0] t;

    cmpVec[0] = '{8'h80, 1'b0};
    cmpVec[1] = '{8'h40, 1'b1};
    cmpVec[2] = '{8'h60, 1'b0};
    cmpVec[3] = '{8'h50, 1'b1};
    cmpVec[4] = '{8'h58, 1'b1};
    cmpVec[5] = '{8'h5C, 1'b0};
    cmpVec[6] = '{8'h5A, 1'b1};
    cmpVec[7] = '{8'h5B, 1'b0};

    convVec[0] = '{8'h00, 8'h00, 1'b1};
    convVec[1] = '{8'hFF, 8'hFF, 1'b1};
    convVec[2] = '{8'h5A, 8'h5A, 1'b1};
    convVec[3] = '{8'h80, 8'h80, 1'b1};

    bus.target_load = 1'b0;
    bus.target_in   = 8'h00;
    bus.trial_code  = 8'h00;
    bus.sar_done    = 1'b0;

    doReset();
    checkIdle("reset", 8'd0, 8'd0);
    checkOutput("reset result", 32'(bus.result), 32'd0);
    checkOutput("reset match", 32'(bus.match), 32'd0);

`ifdef SAR_LFSR_EN
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'hA5, 1'b1);
    checkOutput("lfsr first match", 32'(bus.match), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hA5, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h4A, 1'b1);
    checkOutput("lfsr second match", 32'(bus.match), 32'd1);
    checkOutput("lfsr pass_cnt", 32'(bus.pass_cnt), 32'd2);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h4A, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h4A, 1'b1);
    checkOutput("lfsr ignores target_in", 32'(bus.match), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
`else
    // Comparator latency: answer to trial n appears one cycle later.
    applyStimulus(1'b1, 8'h5A, 8'h00, 1'b0);
    checkOutput("load busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, cmpVec[i].trial, 1'b0);
      checkOutput($sformatf("comp trial 0x%0h", cmpVec[i].trial),
                  32'(bus.comp_out), 32'(cmpVec[i].expComp));
    end
    applyStimulus(1'b0, 8'h00, 8'h5A, 1'b1);
    checkOutput("cmp final match", 32'(bus.match), 32'd1);
    checkOutput("cmp pass_cnt", 32'(bus.pass_cnt), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a conversion.
    applyStimulus(1'b1, 8'h5A, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h80, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h40, 1'b0);
    checkOutput("midreset busy before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h5A, 1'b1);
    rst_n = 1'b1;
    checkIdle("midreset", 8'd0, 8'd0);
    checkOutput("midreset result", 32'(bus.result), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h5A, 1'b1);
    checkIdle("midreset idle done", 8'd0, 8'd0);

    // Full reference SAR loop against boundary and mid-scale targets.
    for (int i = 0; i < 4; i++) begin
      runSar(convVec[i].target, convVec[i].expResult, convVec[i].expMatch);
    end
    checkOutput("loop pass_cnt", 32'(bus.pass_cnt), 32'd4);
    checkOutput("loop fail_cnt", 32'(bus.fail_cnt), 32'd0);

    // Wrong final code.
    applyStimulus(1'b1, 8'h33, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h34, 1'b1);
    checkOutput("wrong valid", 32'(bus.result_valid), 32'd1);
    checkOutput("wrong match", 32'(bus.match), 32'd0);
    checkOutput("wrong result", 32'(bus.result), 32'h34);
    checkOutput("wrong fail_cnt", 32'(bus.fail_cnt), 32'd1);
    checkOutput("wrong pass_cnt", 32'(bus.pass_cnt), 32'd4);
    applyStimulus(1'b1, 8'h10, 8'h00, 1'b0);
    checkOutput("load in CHECK ignored", 32'(bus.busy), 32'd0);

    // Timeout: no sar_done, expect the pulse after the 16th CONVERT cycle.
    applyStimulus(1'b1, 8'h10, 8'h00, 1'b0);
    seen = 0;
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      if (bus.timeout) begin
        seen = k;
        break;
      end
    end
    checkOutput("timeout cycle", 32'(seen), 32'(TIMEOUT_CYCLES));
    checkOutput("timeout busy", 32'(bus.busy), 32'd0);
    checkOutput("timeout fail_cnt", 32'(bus.fail_cnt), 32'd2);
    checkOutput("timeout result kept", 32'(bus.result), 32'h34);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 8'h10, 1'b1);
      checkIdle("idle done ignored", 8'd4, 8'd2);
    end
    checkOutput("idle done result", 32'(bus.result), 32'h34);

    // Saturation of pass_cnt.
    for (int i = 0; i < 260; i++) begin
      t = 8'(i);
      applyStimulus(1'b1, t, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, t, 1'b1);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    end
    checkOutput("sat pass_cnt", 32'(bus.pass_cnt), 32'hFF);
    checkOutput("sat fail_cnt", 32'(bus.fail_cnt), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_cmp_responder.md
Name: sar_cmp_responder

Overview:
- Digital stand-in for the analog front end of the 8-bit SAR converter.
- Holds a target code and answers each SAR trial code with a registered comparator bit.
- Captures the final code when the SAR signals done, checks it against the target, and keeps pass/fail/timeout statistics.
- Sits on the SAR's comparator input and code/done outputs; used in self-checking bring-up builds and in benches.

Parameters:
- WIDTH, 8, code width of target/trial/result.
- CNT_WIDTH, 8, width of the pass and fail counters.
- TIMEOUT_CYCLES, 16, CONVERT cycles allowed before a timeout is declared; must be >= WIDTH+2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- target_in  input  WIDTH  target code, sampled on target_load.
- target_load  input  1  one-cycle request to start a conversion check.
- trial_code  input  WIDTH  SAR's current trial/result code.
- sar_done  input  1  SAR conversion-complete flag.
- comp_out  output  1  comparator bit to SAR; 1 = target >= trial (keep bit).
- busy  output  1  high in CONVERT and CHECK.
- result  output  WIDTH  captured final SAR code.
- result_valid  output  1  one-cycle pulse when result/match are updated.
- match  output  1  result == target, valid from the result_valid pulse until the next one.
- timeout  output  1  one-cycle pulse when the SAR fails to finish in time.
- pass_cnt  output  CNT_WIDTH  number of matching conversions.
- fail_cnt  output  CNT_WIDTH  number of mismatches plus timeouts.

Behaviour:
- Reset (rst_n low at a rising edge) clears all outputs, target, and the cycle counter, and forces IDLE.
- Reset applies mid-conversion with no result or counter update.
- States: IDLE, CONVERT, CHECK.
- IDLE:
  - comp_out = 0, busy = 0.
  - target_load = 1: latch target <= target_in, clear cycle counter, go to CONVERT.
  - sar_done is ignored.
- CONVERT, each cycle:
  - comp_out <= (target >= trial_code), unsigned compare. One-cycle latency: the trial presented in cycle n gives comp_out in cycle n+1.
  - cycle counter increments.
  - target_load is ignored.
- Done vs timeout in CONVERT:
  - sar_done = 1: result <= trial_code, go to CHECK. Done has priority over timeout on the same cycle.
  - Counter reaches TIMEOUT_CYCLES without sar_done: timeout pulses 1 cycle, fail_cnt++, go to IDLE, result unchanged.
- CHECK (exactly 1 cycle):
  - result_valid = 1.
  - match = (result == target).
  - pass_cnt++ if matched, else fail_cnt++.
  - Go to IDLE.
- target_load asserted during CHECK is ignored; a new check starts only from IDLE.
- Counters saturate at all-ones and never wrap.
- result and match hold their values until the next CHECK.

Optional Feature:
- Macro: SAR_LFSR_EN.
- Defined:
  - target_load latches target from an internal 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset); target_in is ignored.
  - The LFSR advances one step on each accepted target_load.
  - For WIDTH > 8, the upper target bits are 0.
- Not defined: no LFSR logic is present, and target comes from target_in.

Test Plan:
- Reset mid-CONVERT with target 0x5A: all outputs 0, state IDLE, pass_cnt and fail_cnt 0 on the next cycle.
- Directed comparator check: load 0x5A, drive trials 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B. comp_out one cycle later must be 0, 1, 0, 1, 1, 0, 1, 0.
- Full SAR loop with a reference binary-search model, targets 0x00, 0xFF, 0x5A, 0x80:
  - each gives result = target, match = 1, one result_valid pulse;
  - pass_cnt = 4 at the end.
- Wrong final code: target 0x33, sar_done with trial 0x34 -> match = 0, fail_cnt increments by 1, pass_cnt unchanged.
- No sar_done after load: timeout pulses at CONVERT cycle 16, fail_cnt +1, busy drops; sar_done asserted in IDLE afterward has no effect.
- Saturation: 260 matching conversions -> pass_cnt holds 0xFF.
- With SAR_LFSR_EN: first two loaded targets are 0xA5 and the next LFSR value; target_in changes have no effect.
